// File: rtl/i2c_bus_sampler_if.sv
// I2C receive front-end interface: raw SCL/SDA lines in, START/STOP events and
// received bit strobes out. The master side drives the bus lines, the slave
// side is the sampler itself.
interface i2c_bus_sampler_if;
   logic       SCL;
   logic       SDA;
   logic       Start;
   logic       RXIn;
   logic       ValidRxDIn;
   logic       AckBit;
   logic       AckValid;
   logic       StopDet;
   logic       RepStart;
   logic       BusErr;
   logic [3:0] BitCount;

   modport master (
      output SCL, SDA,
      input  Start, RXIn, ValidRxDIn, AckBit, AckValid,
             StopDet, RepStart, BusErr, BitCount
   );

   modport slave (
      input  SCL, SDA,
      output Start, RXIn, ValidRxDIn, AckBit, AckValid,
             StopDet, RepStart, BusErr, BitCount
   );
endinterface

// File: rtl/i2c_bus_sampler.sv
// i2c_bus_sampler: receive front end of the I2C slave.
// Oversamples SCL/SDA on clk, detects START / repeated START / STOP and emits
// one-cycle strobes for each data bit and for the ninth (ACK) bit.
// Optional glitch filter enabled by defining I2C_GLITCH_FILTER_EN; the filter
// depth is FILT_LEN (2..8) clk cycles.
module i2c_bus_sampler #(
   parameter int FILT_LEN = 3
) (
   input logic              clk,
   input logic              rst_n,
   i2c_bus_sampler_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic scl_p0, scl_p1;
   logic sda_p0, sda_p1;
   logic scl_f, sda_f;
   logic scl_q, sda_q;

   logic       scl_rise;
   logic       sda_rise;
   logic       sda_fall;
   logic       start_cond;
   logic       stop_cond;

   logic [1:0] state;
   logic [3:0] bit_count;
   logic       start_q;
   logic       rx_bit;
   logic       rx_vld;
   logic       ack_bit;
   logic       ack_vld;
   logic       stop_det;
   logic       rep_start;
   logic       bus_err;

   // Two-flop synchronizers; idle bus level is high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
      end else begin
         scl_p0 <= bus.SCL;
         scl_p1 <= scl_p0;
         sda_p0 <= bus.SDA;
         sda_p1 <= sda_p0;
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   localparam int CNT_W = $clog2(FILT_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

   logic [CNT_W-1:0] scl_cnt, sda_cnt;
   logic             scl_flt, sda_flt;

   // Filtered level follows the synchronized line only after FILT_LEN
   // consecutive samples at the new level; any reversion restarts the count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_cnt <= '0;
         sda_cnt <= '0;
         scl_flt <= 1'b1;
         sda_flt <= 1'b1;
      end else begin
         if (scl_p1 == scl_flt) begin
            scl_cnt <= '0;
         end else if (scl_cnt == CNT_MAX) begin
            scl_cnt <= '0;
            scl_flt <= scl_p1;
         end else begin
            scl_cnt <= scl_cnt + 1'b1;
         end
         if (sda_p1 == sda_flt) begin
            sda_cnt <= '0;
         end else if (sda_cnt == CNT_MAX) begin
            sda_cnt <= '0;
            sda_flt <= sda_p1;
         end else begin
            sda_cnt <= sda_cnt + 1'b1;
         end
      end
   end

   assign scl_f = scl_flt;
   assign sda_f = sda_flt;
`else
   assign scl_f = scl_p1;
   assign sda_f = sda_p1;
`endif

   // Previous filtered levels for edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign scl_rise = scl_f & ~scl_q;
   assign sda_rise = sda_f & ~sda_q;
   assign sda_fall = ~sda_f & sda_q;

   // SDA edges count as START/STOP only while SCL is stably high, so an SDA
   // edge coinciding with an SCL edge is treated as data movement
   assign start_cond = sda_fall & scl_f & scl_q;
   assign stop_cond  = sda_rise & scl_f & scl_q;

   // Bus protocol FSM: tracks the bit slot and produces all strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_count <= 4'd0;
         start_q   <= 1'b0;
         rx_bit    <= 1'b1;
         rx_vld    <= 1'b0;
         ack_bit   <= 1'b1;
         ack_vld   <= 1'b0;
         stop_det  <= 1'b0;
         rep_start <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         rx_vld    <= 1'b0;
         ack_vld   <= 1'b0;
         stop_det  <= 1'b0;
         rep_start <= 1'b0;
         bus_err   <= 1'b0;
         if (start_cond) begin
            if (state != ST_IDLE) begin
               rep_start <= 1'b1;
               bus_err   <= (bit_count != 4'd0);
            end
            start_q   <= 1'b1;
            bit_count <= 4'd0;
            state     <= ST_DATA;
         end else if (stop_cond) begin
            if (state != ST_IDLE) begin
               stop_det  <= 1'b1;
               bus_err   <= (bit_count != 4'd0);
               start_q   <= 1'b0;
               bit_count <= 4'd0;
               state     <= ST_IDLE;
            end
         end else if (scl_rise) begin
            case (state)
               ST_DATA: begin
                  rx_bit    <= sda_f;
                  rx_vld    <= 1'b1;
                  bit_count <= bit_count + 4'd1;
                  if (bit_count == 4'd7) begin
                     state <= ST_ACK;
                  end
               end
               ST_ACK: begin
                  ack_bit   <= sda_f;
                  ack_vld   <= 1'b1;
                  bit_count <= 4'd0;
                  state     <= ST_DATA;
               end
               ST_IDLE: begin
               end
               default: begin
                  state     <= ST_IDLE;
                  start_q   <= 1'b0;
                  bit_count <= 4'd0;
               end
            endcase
         end
      end
   end

   assign bus.Start      = start_q;
   assign bus.RXIn       = rx_bit;
   assign bus.ValidRxDIn = rx_vld;
   assign bus.AckBit     = ack_bit;
   assign bus.AckValid   = ack_vld;
   assign bus.StopDet    = stop_det;
   assign bus.RepStart   = rep_start;
   assign bus.BusErr     = bus_err;
   assign bus.BitCount   = bit_count;

endmodule

// File: tb/tb_i2c_bus_sampler.sv
// Directed testbench for i2c_bus_sampler. Honours I2C_GLITCH_FILTER_EN for
// latency and glitch expectations.
module tb_i2c_bus_sampler;

   localparam int FILT_LEN = 3;
   localparam int H = 12;
`ifdef I2C_GLITCH_FILTER_EN
   localparam int LAT = 3 + FILT_LEN;
   localparam int GLITCH_VLD = 0;
`else
   localparam int LAT = 3;
   localparam int GLITCH_VLD = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   i2c_bus_sampler_if bus ();

   i2c_bus_sampler #(.FILT_LEN(FILT_LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int         n_vld, n_ack, n_stop, n_rep, n_err, n_stop_err, n_start_low, n_bc_bad;
   logic [7:0] rx_bits;
   logic [3:0] bc_snap;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear();
      n_vld = 0; n_ack = 0; n_stop = 0; n_rep = 0; n_err = 0;
      n_stop_err = 0; n_start_low = 0; n_bc_bad = 0; rx_bits = 8'h00;
   endtask

   // Advance n cycles, sampling 1 time unit after each rising edge
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus.ValidRxDIn) begin
            rx_bits = {rx_bits[6:0], bus.RXIn};
            n_vld++;
            if (bus.BitCount != 4'(n_vld)) n_bc_bad++;
         end
         if (bus.AckValid) n_ack++;
         if (bus.StopDet)  n_stop++;
         if (bus.RepStart) n_rep++;
         if (bus.BusErr)   n_err++;
         if (bus.StopDet && bus.BusErr) n_stop_err++;
         if (!bus.Start)   n_start_low++;
      end
   endtask

   // SCL low on entry; leaves SCL high with SDA = b
   task automatic clock_hi(input logic b);
      bus.SDA = b;
      run(H);
      bus.SCL = 1'b1;
      run(H);
   endtask

   task automatic send_bit(input logic b);
      clock_hi(b);
      bus.SCL = 1'b0;
      run(H);
   endtask

   // SCL and SDA high on entry
   task automatic do_start();
      bus.SDA = 1'b0;
      run(H);
      bus.SCL = 1'b0;
      run(H);
   endtask

   initial begin
      logic [7:0] byte_a2;
      byte_a2 = 8'hA2;
      bus.SCL = 1'b1;
      bus.SDA = 1'b1;
      clear();

      // Reset held 4 cycles with idle bus
      rst_n = 1'b0;
      run(4);
      chk("rst_start",    32'(bus.Start), 32'd0);
      chk("rst_rxin",     32'(bus.RXIn), 32'd1);
      chk("rst_vld",      32'(bus.ValidRxDIn), 32'd0);
      chk("rst_ackbit",   32'(bus.AckBit), 32'd1);
      chk("rst_ackvld",   32'(bus.AckValid), 32'd0);
      chk("rst_stop",     32'(bus.StopDet), 32'd0);
      chk("rst_rep",      32'(bus.RepStart), 32'd0);
      chk("rst_buserr",   32'(bus.BusErr), 32'd0);
      chk("rst_bitcount", 32'(bus.BitCount), 32'd0);
      rst_n = 1'b1;
      run(2);

      // START then byte 0xA2, ACK = 0
      do_start();
      chk("start_hi",     32'(bus.Start), 32'd1);
      chk("start_bc",     32'(bus.BitCount), 32'd0);
      clear();
      for (int i = 7; i >= 0; i--) send_bit(byte_a2[i]);
      chk("byte_nvld",    32'(n_vld), 32'd8);
      chk("byte_bits",    32'(rx_bits), 32'hA2);
      chk("byte_bc_align",32'(n_bc_bad), 32'd0);
      chk("byte_bc8",     32'(bus.BitCount), 32'd8);
      // ACK slot; SCL left high so the STOP follows directly
      clock_hi(1'b0);
      chk("ack_cnt",      32'(n_ack), 32'd1);
      chk("ack_bit",      32'(bus.AckBit), 32'd0);
      chk("ack_bc0",      32'(bus.BitCount), 32'd0);
      chk("byte_start_hi",32'(n_start_low), 32'd0);
      chk("byte_nerr",    32'(n_err), 32'd0);

      // STOP with exact latency
      clear();
      bus.SDA = 1'b1;
      run(LAT - 1);
      chk("stop_early",   32'(bus.StopDet), 32'd0);
      chk("stop_early_st",32'(bus.Start), 32'd1);
      run(1);
      chk("stop_pulse",   32'(bus.StopDet), 32'd1);
      chk("stop_start0",  32'(bus.Start), 32'd0);
      chk("stop_noerr",   32'(bus.BusErr), 32'd0);
      run(H);
      chk("stop_cnt",     32'(n_stop), 32'd1);

      // STOP after 3 bits
      do_start();
      clear();
      send_bit(1'b1);
      send_bit(1'b0);
      clock_hi(1'b0);
      chk("abort_bc3",    32'(bus.BitCount), 32'd3);
      bus.SDA = 1'b1;
      run(H);
      chk("abort_stop",   32'(n_stop), 32'd1);
      chk("abort_err",    32'(n_err), 32'd1);
      chk("abort_both",   32'(n_stop_err), 32'd1);
      chk("abort_start0", 32'(bus.Start), 32'd0);
      chk("abort_bc0",    32'(bus.BitCount), 32'd0);

      // Repeated START after 5 bits
      do_start();
      clear();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      clock_hi(1'b1);
      bus.SDA = 1'b0;
      run(H);
      chk("rep_cnt",      32'(n_rep), 32'd1);
      chk("rep_err",      32'(n_err), 32'd1);
      chk("rep_nostop",   32'(n_stop), 32'd0);
      chk("rep_start_hi", 32'(n_start_low), 32'd0);
      chk("rep_bc0",      32'(bus.BitCount), 32'd0);
      bus.SCL = 1'b0;
      run(H);

      // One-cycle SCL high glitch during DATA
      clear();
      bus.SDA = 1'b1;
      run(H);
      bus.SCL = 1'b1;
      run(1);
      bus.SCL = 1'b0;
      run(H);
      chk("glitch_nvld",  32'(n_vld), 32'(GLITCH_VLD));
      chk("glitch_bc",    32'(bus.BitCount), 32'(GLITCH_VLD));

      // Simultaneous SCL/SDA fall while SCL high: not a START
      bus.SCL = 1'b1;
      run(H);
      chk("sim_pre_bc",   32'(bus.BitCount), 32'(GLITCH_VLD + 1));
      bc_snap = bus.BitCount;
      clear();
      bus.SCL = 1'b0;
      bus.SDA = 1'b0;
      run(H);
      chk("sim_norep",    32'(n_rep), 32'd0);
      chk("sim_noerr",    32'(n_err), 32'd0);
      chk("sim_nostop",   32'(n_stop), 32'd0);
      chk("sim_bc",       32'(bus.BitCount), 32'(bc_snap));
      chk("sim_start",    32'(bus.Start), 32'd1);

      // Reset mid-byte discards silently
      clear();
      rst_n = 1'b0;
      run(1);
      chk("mrst_start",   32'(bus.Start), 32'd0);
      chk("mrst_bc",      32'(bus.BitCount), 32'd0);
      chk("mrst_stop",    32'(n_stop), 32'd0);
      chk("mrst_err",     32'(n_err), 32'd0);
      rst_n = 1'b1;
      run(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Overall time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
